// File: rtl/dmem_stall_ctrl.sv
// Data-memory stall controller: freezes the pipeline while a
// multi-cycle load/store runs through an IDLE-WAIT-DONE handshake.
module dmem_stall_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              EXMEM_MemRead_i,
  input  logic              EXMEM_MemWrite_i,
  input  logic [DATA_W-1:0] EXMEM_Addr_i,
  input  logic [DATA_W-1:0] EXMEM_WData_i,
  output logic              MemStall_o,
  output logic [DATA_W-1:0] RData_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [31:0]       StallCnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              stall;
  logic              capture;
  logic              load_rdata;
  logic              access;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [31:0]       stall_cnt;

  assign access = EXMEM_MemRead_i | EXMEM_MemWrite_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, stall and capture/load strobes
  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    capture    = 1'b0;
    load_rdata = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack_i) begin
          load_rdata = ~we_q;
          state_d    = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign MemStall_o = stall & ~rst_i;
  assign mem_req_o  = (state_q == WAIT);

  // Request capture, read-data return and stall counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      stall_cnt <= '0;
    end else begin
      if (capture) begin
        we_q    <= EXMEM_MemWrite_i & ~EXMEM_MemRead_i;
        addr_q  <= EXMEM_Addr_i;
        wdata_q <= EXMEM_WData_i;
      end
      if (load_rdata) rdata_q <= mem_rdata_i;
      if (MemStall_o) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign RData_o     = rdata_q;
  assign StallCnt_o  = stall_cnt;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Bench for dmem_stall_ctrl: table of per-cycle vectors plus
// hand-written back-to-back, reset-abort and counter-wrap sequences.
module tb_dmem_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        req;
  logic        we;
  logic [31:0] maddr;
  logic [31:0] mwdata;
  logic        ack;
  logic [31:0] mrdata;
  logic [31:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_stall_ctrl #(.DATA_W(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .EXMEM_MemRead_i  (rd),
    .EXMEM_MemWrite_i (wr),
    .EXMEM_Addr_i     (addr),
    .EXMEM_WData_i    (wdata),
    .MemStall_o       (stall),
    .RData_o          (rdata),
    .mem_req_o        (req),
    .mem_we_o         (we),
    .mem_addr_o       (maddr),
    .mem_wdata_o      (mwdata),
    .mem_ack_i        (ack),
    .mem_rdata_i      (mrdata),
    .StallCnt_o       (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic [31:0] rdt;
    logic        e_stall;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string t,
                         input logic e_stall, input logic e_req,
                         input logic e_we,
                         input logic [31:0] e_addr,
                         input logic [31:0] e_wd,
                         input logic [31:0] e_rd,
                         input logic [31:0] e_cnt);
    chk({t, " stall"}, {31'd0, stall}, {31'd0, e_stall});
    chk({t, " req"},   {31'd0, req},   {31'd0, e_req});
    chk({t, " we"},    {31'd0, we},    {31'd0, e_we});
    chk({t, " addr"},  maddr,  e_addr);
    chk({t, " wdata"}, mwdata, e_wd);
    chk({t, " rdata"}, rdata,  e_rd);
    chk({t, " cnt"},   cnt,    e_cnt);
  endtask

  // Drive one cycle at posedge+1, check at posedge+2, advance.
  task automatic cyc(input string t, input vec_t v);
    rd     = v.rd;
    wr     = v.wr;
    addr   = v.addr;
    wdata  = v.wd;
    ack    = v.ack;
    mrdata = v.rdt;
    #1;
    chk_all(t, v.e_stall, v.e_req, v.e_we, v.e_addr,
            v.e_wd, v.e_rd, v.e_cnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      // load 0x40, ack on 3rd WAIT cycle
      '{1, 0, 32'h40, 0, 0, 0,
        1, 0, 0, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 0,
        1, 1, 0, 32'h40, 0, 0, 1},
      '{0, 0, 0, 0, 0, 0,
        1, 1, 0, 32'h40, 0, 0, 2},
      '{0, 0, 0, 0, 1, 32'hDEADBEEF,
        1, 1, 0, 32'h40, 0, 0, 3},
      '{1, 0, 32'h44, 0, 1, 32'h55,
        0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 4},
      '{0, 0, 0, 0, 1, 32'h66,
        0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 4},
      // store 0x80, ack on 1st WAIT cycle
      '{0, 1, 32'h80, 32'h12345678, 0, 0,
        1, 0, 0, 32'h40, 0, 32'hDEADBEEF, 4},
      '{1, 0, 32'hFF, 32'hFFFFFFFF, 1, 32'hBAD,
        1, 1, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, 5},
      '{0, 0, 0, 0, 0, 0,
        0, 0, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, 6},
      '{0, 0, 0, 0, 0, 0,
        0, 0, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, 6},
      // read and write both high: read wins
      '{1, 1, 32'hC0, 32'hAAAA5555, 0, 0,
        1, 0, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, 6},
      '{0, 0, 0, 0, 1, 32'h0BADF00D,
        1, 1, 0, 32'hC0, 32'hAAAA5555, 32'hDEADBEEF, 7},
      '{0, 0, 0, 0, 0, 0,
        0, 0, 0, 32'hC0, 32'hAAAA5555, 32'h0BADF00D, 8},
      '{0, 0, 0, 0, 0, 0,
        0, 0, 0, 32'hC0, 32'hAAAA5555, 32'h0BADF00D, 8}
    };

    rst = 1'b1; rd = 0; wr = 0; addr = 0; wdata = 0;
    ack = 0; mrdata = 0;
    rd = 1'b1;
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rd = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      cyc($sformatf("vec%0d", i), vecs[i]);

    // back-to-back loads: DONE bubble between them
    cyc("b2b0", '{1, 0, 32'h100, 0, 0, 0,
                  1, 0, 0, 32'hC0, 32'hAAAA5555, 32'h0BADF00D, 8});
    cyc("b2b1", '{1, 0, 32'h100, 0, 1, 32'h11111111,
                  1, 1, 0, 32'h100, 0, 32'h0BADF00D, 9});
    cyc("b2b2", '{1, 0, 32'h104, 0, 0, 0,
                  0, 0, 0, 32'h100, 0, 32'h11111111, 10});
    cyc("b2b3", '{1, 0, 32'h104, 0, 0, 0,
                  1, 0, 0, 32'h100, 0, 32'h11111111, 10});
    cyc("b2b4", '{0, 0, 0, 0, 1, 32'h22222222,
                  1, 1, 0, 32'h104, 0, 32'h11111111, 11});
    cyc("b2b5", '{0, 0, 0, 0, 0, 0,
                  0, 0, 0, 32'h104, 0, 32'h22222222, 12});

    // reset mid-WAIT, late ack ignored
    cyc("rw0", '{1, 0, 32'h200, 32'h77, 0, 0,
                 1, 0, 0, 32'h104, 0, 32'h22222222, 12});
    #1;
    chk_all("rw1", 1, 1, 0, 32'h200, 32'h77, 32'h22222222, 13);
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc("late0", '{0, 0, 0, 0, 1, 32'h99,
                   0, 0, 0, 0, 0, 0, 0});
    cyc("late1", '{0, 0, 0, 0, 1, 32'h99,
                   0, 0, 0, 0, 0, 0, 0});

    // first request after reset
    cyc("pr0", '{1, 0, 32'h300, 0, 0, 0,
                 1, 0, 0, 0, 0, 0, 0});
    cyc("pr1", '{0, 0, 0, 0, 1, 32'h33333333,
                 1, 1, 0, 32'h300, 0, 0, 1});
    cyc("pr2", '{0, 0, 0, 0, 0, 0,
                 0, 0, 0, 32'h300, 0, 32'h33333333, 2});

    // counter wrap through 0xFFFFFFFF
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    cyc("wr0", '{1, 0, 32'h400, 0, 0, 0,
                 1, 0, 0, 32'h300, 0, 32'h33333333, 32'hFFFFFFFE});
    cyc("wr1", '{0, 0, 0, 0, 0, 0,
                 1, 1, 0, 32'h400, 0, 32'h33333333, 32'hFFFFFFFF});
    cyc("wr2", '{0, 0, 0, 0, 1, 32'h44444444,
                 1, 1, 0, 32'h400, 0, 32'h33333333, 0});
    cyc("wr3", '{0, 0, 0, 0, 0, 0,
                 0, 0, 0, 32'h400, 0, 32'h44444444, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
